padded_row_window: RTL

- Parametrised successor to the fixed 416-pixel, 3-channel, pad-1 row padder.
- Accepts unpadded image rows over a valid/ready stream and keeps a (2·PAD+1)-row line buffer.
- Emits one padded vertical window per output row, with zero or edge-replicate padding on all four borders.
- Sits between the DMA row loader and the convolution array, and pulses `frame_done` when a frame's last window has been consumed.

---
 rtl/padding_pkg.sv | 43 ++++
 rtl/padding_row_pad.sv | 32 +++
 rtl/padded_row_window.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/padding_pkg.sv
// Shared types and derived-size helpers for the padded row window block.
package padding_pkg;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } pad_state_t;

   // Window height in rows.
   function automatic int unsigned win_k(input int unsigned pad);
      return 2 * pad + 1;
   endfunction

   // Bits in one padded single-channel row.
   function automatic int unsigned pix_w(input int unsigned data_w, input int unsigned img_w,
                                         input int unsigned pad);
      return (img_w + 2 * pad) * data_w;
   endfunction

   // Bits in one padded multi-channel row.
   function automatic int unsigned row_w(input int unsigned ch, input int unsigned data_w,
                                         input int unsigned img_w, input int unsigned pad);
      return ch * pix_w(data_w, img_w, pad);
   endfunction

   // Bits in one unpadded multi-channel row.
   function automatic int unsigned raw_w(input int unsigned ch, input int unsigned data_w,
                                         input int unsigned img_w);
      return ch * img_w * data_w;
   endfunction

   // Row counter / index width.
   function automatic int unsigned cnt_w(input int unsigned img_h);
      return (img_h > 1) ? $clog2(img_h) : 1;
   endfunction

   // Line-buffer slot select width.
   function automatic int unsigned sel_w(input int unsigned k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/padding_row_pad.sv
// Combinational horizontal padder: widens every channel of one row by PAD pixels per side.
module padding_row_pad
   import padding_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IMG_W  = 416,
   parameter int unsigned CH     = 3,
   parameter int unsigned PAD    = 1
) (
   input  logic                                    mode,
   input  logic [raw_w(CH, DATA_W, IMG_W)-1:0]     raw,
   output logic [row_w(CH, DATA_W, IMG_W, PAD)-1:0] padded_c
);

   localparam int unsigned PW_PIX = IMG_W + 2 * PAD;

   for (genvar c = 0; c < int'(CH); c++) begin : g_ch
      for (genvar j = 0; j < int'(PW_PIX); j++) begin : g_pix
         if (j < int'(PAD)) begin : g_left
            assign padded_c[(c * PW_PIX + j) * DATA_W +: DATA_W] =
               mode ? raw[(c * IMG_W) * DATA_W +: DATA_W] : '0;
         end else if (j >= int'(PAD + IMG_W)) begin : g_right
            assign padded_c[(c * PW_PIX + j) * DATA_W +: DATA_W] =
               mode ? raw[(c * IMG_W + IMG_W - 1) * DATA_W +: DATA_W] : '0;
         end else begin : g_body
            assign padded_c[(c * PW_PIX + j) * DATA_W +: DATA_W] =
               raw[(c * IMG_W + j - PAD) * DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/padded_row_window.sv
// Row line buffer that emits one zero- or edge-padded K-row vertical window per output row.
module padded_row_window
   import padding_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IMG_W  = 416,
   parameter int unsigned IMG_H  = 416,
   parameter int unsigned CH     = 3,
   parameter int unsigned PAD    = 1
) (
   input  logic                                                      clk,
   input  logic                                                      reset,
   input  logic                                                      pad_mode,
   input  logic                                                      in_valid,
   output logic                                                      in_ready,
   input  logic [raw_w(CH, DATA_W, IMG_W)-1:0]                       in_row,
   output logic                                                      out_valid,
   input  logic                                                      out_ready,
   output logic [win_k(PAD)*row_w(CH, DATA_W, IMG_W, PAD)-1:0]        out_win,
   output logic [cnt_w(IMG_H)-1:0]                                   out_row_idx,
   output logic                                                      frame_done
);

   localparam int unsigned K     = win_k(PAD);
   localparam int unsigned RAW_W = raw_w(CH, DATA_W, IMG_W);
   localparam int unsigned ROW_W = row_w(CH, DATA_W, IMG_W, PAD);
   localparam int unsigned WIN_W = K * ROW_W;
   localparam int unsigned CNT_W = cnt_w(IMG_H);
   localparam int unsigned SEL_W = sel_w(K);

   if (PAD < 1 || PAD > 2 || IMG_H < PAD + 1) begin : g_bad_param
      $error("padded_row_window: illegal PAD/IMG_H combination");
   end

   pad_state_t         state_q, state_d;
   logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
   logic               mode_q, mode_d;
   logic               valid_d, frame_done_d;
   logic [WIN_W-1:0]   win_d, win_next;
   logic               shift, load, slot_free;

   logic [RAW_W-1:0]   lb       [K];
   logic [RAW_W-1:0]   src      [K];
   logic [RAW_W-1:0]   slot_raw [K];
   logic [ROW_W-1:0]   slot_pad [K];

   int                 last_row, win_idx, src_row, pos;

   // Newest row sits in slot 0; the oldest retained row falls off the end.
   always_ff @(posedge clk) begin : line_buffer
      if (shift) begin
         lb[0] <= in_row;
         for (int i = 1; i < int'(K); i++) lb[i] <= lb[i-1];
      end
   end

   // Build the window from the buffer as it will look after this edge's shift.
   always_comb begin : slot_select
      src[0] = shift ? in_row : lb[0];
      for (int i = 1; i < int'(K); i++) src[i] = shift ? lb[i-1] : lb[i];

      last_row = shift ? int'(in_cnt_q) : int'(IMG_H) - 1;
      win_idx  = shift ? int'(in_cnt_q) - int'(PAD) : int'(out_cnt_q) + 1;
      src_row  = 0;
      pos      = 0;
      win_next = '0;

      for (int k = 0; k < int'(K); k++) begin
         src_row = win_idx - int'(PAD) + k;
         if (src_row < 0)             pos = last_row;
         else if (src_row > last_row) pos = 0;
         else                         pos = last_row - src_row;

         slot_raw[k] = '0;
         if (((src_row >= 0) && (src_row <= last_row)) || mode_q) begin
            if (pos < int'(K)) slot_raw[k] = src[SEL_W'(pos)];
         end
         win_next[k*ROW_W +: ROW_W] = slot_pad[k];
      end
   end

   for (genvar k = 0; k < int'(K); k++) begin : g_pad
      padding_row_pad #(
         .DATA_W (DATA_W),
         .IMG_W  (IMG_W),
         .CH     (CH),
         .PAD    (PAD)
      ) u_row_pad (
         .mode     (mode_q),
         .raw      (slot_raw[k]),
         .padded_c (slot_pad[k])
      );
   end

   // Next-state, handshake and window-load decisions.
   always_comb begin : fsm_next
      state_d      = state_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      mode_d       = mode_q;
      valid_d      = out_valid;
      win_d        = out_win;
      frame_done_d = 1'b0;
      shift        = 1'b0;
      load         = 1'b0;
      in_ready     = 1'b0;
      slot_free    = !out_valid || out_ready;

      case (state_q)
         ST_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shift = 1'b1;
               if (in_cnt_q == '0) mode_d = pad_mode;
               if (in_cnt_q == CNT_W'(IMG_H - 1)) begin
                  load    = 1'b1;
                  state_d = ST_DRAIN;
               end else begin
                  in_cnt_d = in_cnt_q + CNT_W'(1);
                  if (in_cnt_q == CNT_W'(PAD)) begin
                     load    = 1'b1;
                     state_d = ST_STREAM;
                  end
               end
            end
         end
         ST_STREAM: begin
            in_ready = slot_free;
            if (in_valid && slot_free) begin
               shift = 1'b1;
               load  = 1'b1;
               if (in_cnt_q == CNT_W'(IMG_H - 1)) state_d = ST_DRAIN;
               else                               in_cnt_d = in_cnt_q + CNT_W'(1);
            end else if (out_valid && out_ready) begin
               valid_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (out_cnt_q == CNT_W'(IMG_H - 1)) begin
               if (out_valid && out_ready) begin
                  valid_d      = 1'b0;
                  frame_done_d = 1'b1;
                  in_cnt_d     = '0;
                  out_cnt_d    = '0;
                  state_d      = ST_FILL;
               end
            end else if (slot_free) begin
               load = 1'b1;
            end
         end
         default: state_d = ST_FILL;
      endcase

      if (load) begin
         valid_d   = 1'b1;
         win_d     = win_next;
         out_cnt_d = CNT_W'(win_idx);
      end
   end

   always_ff @(posedge clk or negedge reset) begin : fsm_state
      if (!reset) begin
         state_q    <= ST_FILL;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         mode_q     <= 1'b0;
         out_valid  <= 1'b0;
         out_win    <= '0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         mode_q     <= mode_d;
         out_valid  <= valid_d;
         out_win    <= win_d;
         frame_done <= frame_done_d;
      end
   end

   assign out_row_idx = out_cnt_q;

endmodule
